// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states and memory geometry.
package definitions;

  typedef logic [31:0] Register;
  typedef logic        Signal;

  localparam Signal ENABLE  = 1'b1;
  localparam Signal DISABLE = 1'b0;

  localparam int MemAddrWidth = 8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } AccessSize;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } LsuState;

endpackage

// File: rtl/load_store_unit_lane_merge.sv
// Combinational lane logic: merges store data into a memory word and extracts/extends load data.
module lsu_lane_merge
  import definitions::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_lane,
  input  logic        i_unsigned,
  output logic [31:0] o_merged,
  output logic [31:0] o_load
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[8*i_lane +: 8];
  assign w_half = i_word[16*i_lane[1] +: 16];

  always_comb begin
    o_merged = i_word;
    case (i_size)
      SZ_BYTE: o_merged[8*i_lane +: 8]      = i_wdata[7:0];
      SZ_HALF: o_merged[16*i_lane[1] +: 16] = i_wdata[15:0];
      default: o_merged = i_wdata;
    endcase
  end

  always_comb begin
    o_load = i_word;
    case (i_size)
      SZ_BYTE: o_load = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      SZ_HALF: o_load = {{16{~i_unsigned & w_half[15]}}, w_half};
      default: o_load = i_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between datapath and word-wide memory; sub-word stores use read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to report misaligned accesses as errors instead of aligning them down.
module load_store_unit
  import definitions::*;
#(
  parameter int unsigned MEM_BYTES = 4 * (2 ** MemAddrWidth)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  LsuState     r_state;
  Register     r_addr;
  Register     r_wdata;
  logic [1:0]  r_size;
  logic        r_write;
  logic        r_unsigned;
  logic        r_ready;
  logic        r_rsp_valid;
  Register     r_rsp_rdata;
  logic        r_rsp_err;
  logic        r_mem_read;
  logic        r_mem_write;
  Register     r_mem_wdata;

  logic        w_reserved;
  logic        w_oor;
  logic        w_err;
  Register     w_eff_addr;
  Register     w_merged;
  Register     w_load;

  assign w_reserved = (req_size == 2'b11);
  assign w_oor      = (req_addr >= MEM_BYTES);

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_misal;
  assign w_misal    = ((req_size == SZ_HALF) && req_addr[0]) ||
                      ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign w_err      = w_reserved | w_oor | w_misal;
  assign w_eff_addr = req_addr;
`else
  assign w_err      = w_reserved | w_oor;
  always_comb begin
    w_eff_addr = req_addr;
    case (req_size)
      SZ_HALF: w_eff_addr = {req_addr[31:1], 1'b0};
      SZ_WORD: w_eff_addr = {req_addr[31:2], 2'b00};
      default: w_eff_addr = req_addr;
    endcase
  end
`endif

  // Lane logic works straight off the combinational memory output during RD.
  lsu_lane_merge u_lane_merge (
    .i_word     (mem_rdata),
    .i_wdata    (r_wdata),
    .i_size     (r_size),
    .i_lane     (r_addr[1:0]),
    .i_unsigned (r_unsigned),
    .o_merged   (w_merged),
    .o_load     (w_load)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_size      <= '0;
      r_write     <= 1'b0;
      r_unsigned  <= 1'b0;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_mem_read  <= DISABLE;
      r_mem_write <= DISABLE;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_addr     <= w_eff_addr;
            r_wdata    <= req_wdata;
            r_size     <= req_size;
            r_write    <= req_write;
            r_unsigned <= req_unsigned;
            r_ready    <= 1'b0;
            if (w_err) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
            end else if (req_write && (req_size == SZ_WORD)) begin
              r_state     <= WR;
              r_mem_write <= ENABLE;
              r_mem_wdata <= req_wdata;
            end else begin
              r_state    <= RD;
              r_mem_read <= ENABLE;
            end
          end
        end
        RD: begin
          r_mem_read <= DISABLE;
          if (r_write) begin
            r_state     <= WR;
            r_mem_write <= ENABLE;
            r_mem_wdata <= w_merged;
          end else begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= w_load;
          end
        end
        WR: begin
          r_mem_write <= DISABLE;
          r_state     <= RESP;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= '0;
        end
        default: begin
          r_state     <= IDLE;
          r_ready     <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= '0;
        end
      endcase
    end
  end

  assign req_ready = r_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign mem_addr  = {r_addr[31:2], 2'b00};
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  localparam int MEMB = 1024;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:255];
  assign mem_rdata = mem[mem_addr[9:2]];

  int cyc = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  always @(posedge clk) begin
    cyc++;
    if (mem_write) begin
      mem[mem_addr[9:2]] = mem_wdata;
      wr_cnt++;
    end
    if (mem_read) rd_cnt++;
  end

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;
  exp_t exp_q[$];

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, "_rdata"}, rsp_rdata, e.rdata);
        chk({e.name, "_err"}, {31'd0, rsp_err}, {31'd0, e.err});
        chk({e.name, "_lat"}, 32'(cyc - e.acc + 1), 32'(e.lat));
      end
    end
  end

  task automatic issue(input string name, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] erd, input logic eerr, input int elat,
                       input bit push);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk({name, "_ready_timeout"}, 32'd0, 32'd1);
      return;
    end
    req_valid    = 1'b1;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    if (push) begin
      e.name = name; e.rdata = erd; e.err = eerr; e.lat = elat; e.acc = cyc + 1;
      exp_q.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !req_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w0, r0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h08] = 32'h11223344;
    mem[8'h0C] = 32'h800000F0;
    mem[8'h10] = 32'hCAFEF00D;

    // reset state
    #12;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: word store then word load back-to-back
    w0 = wr_cnt;
    issue("st_w10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b1);
    issue("ld_w10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b1);
    wait_idle();
    chk("st_w10_wrcnt", 32'(wr_cnt - w0), 32'd1);

    // 2: byte store RMW, then half store and byte load on the same word
    w0 = wr_cnt; r0 = rd_cnt;
    issue("st_b21", 1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AA, 32'h0, 1'b0, 3, 1'b1);
    wait_idle();
    chk("m20_after_b", mem[8'h08], 32'h1122AA44);
    chk("st_b21_rdwr", 32'((wr_cnt - w0) * 16 + (rd_cnt - r0)), 32'h11);
    issue("st_h22", 1'b1, 2'b01, 1'b0, 32'h22, 32'h1234BEEF, 32'h0, 1'b0, 3, 1'b1);
    issue("ld_b23u", 1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 32'h000000BE, 1'b0, 2, 1'b1);
    wait_idle();
    chk("m20_after_h", mem[8'h08], 32'hBEEFAA44);

    // 3: sign/zero extension
    issue("ld_b30s", 1'b0, 2'b00, 1'b0, 32'h30, 32'h0, 32'hFFFFFFF0, 1'b0, 2, 1'b1);
    issue("ld_b30u", 1'b0, 2'b00, 1'b1, 32'h30, 32'h0, 32'h000000F0, 1'b0, 2, 1'b1);
    issue("ld_h32s", 1'b0, 2'b01, 1'b0, 32'h32, 32'h0, 32'hFFFF8000, 1'b0, 2, 1'b1);
    issue("ld_h32u", 1'b0, 2'b01, 1'b1, 32'h32, 32'h0, 32'h00008000, 1'b0, 2, 1'b1);
    issue("ld_b33s", 1'b0, 2'b00, 1'b0, 32'h33, 32'h0, 32'hFFFFFF80, 1'b0, 2, 1'b1);
    wait_idle();

    // 4: misaligned half load
    r0 = rd_cnt;
`ifdef LSU_MISALIGN_TRAP_EN
    issue("ld_h31", 1'b0, 2'b01, 1'b0, 32'h31, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    wait_idle();
    chk("ld_h31_rdcnt", 32'(rd_cnt - r0), 32'd0);
`else
    issue("ld_h31", 1'b0, 2'b01, 1'b0, 32'h31, 32'h0, 32'h000000F0, 1'b0, 2, 1'b1);
    wait_idle();
    chk("ld_h31_rdcnt", 32'(rd_cnt - r0), 32'd1);
`endif

    // 5: out-of-range and reserved size
    r0 = rd_cnt; w0 = wr_cnt;
    issue("ld_oor", 1'b0, 2'b10, 1'b0, 32'(MEMB), 32'h0, 32'h0, 1'b1, 1, 1'b1);
    issue("st_oor", 1'b1, 2'b00, 1'b0, 32'hFFFFFFF0, 32'h55, 32'h0, 1'b1, 1, 1'b1);
    issue("ld_rsv", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    issue("ld_last", 1'b0, 2'b10, 1'b0, 32'(MEMB - 4), 32'h0, 32'h0, 1'b0, 2, 1'b1);
    wait_idle();
    chk("err_no_mem_access", 32'((rd_cnt - r0) * 16 + (wr_cnt - w0)), 32'h10);

    // 6: reset during the RD cycle of a sub-word store
    w0 = wr_cnt;
    issue("st_b40", 1'b1, 2'b00, 1'b0, 32'h40, 32'h00000077, 32'h0, 1'b0, 3, 1'b0);
    chk("st_b40_in_rd", {31'd0, mem_read}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rw", {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mid_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("rst_mid_addr", mem_addr, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("m40_unchanged", mem[8'h10], 32'hCAFEF00D);
    chk("rst_mid_wrcnt", 32'(wr_cnt - w0), 32'd0);
    issue("ld_w40", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0, 2, 1'b1);
    issue("st_b41", 1'b1, 2'b00, 1'b0, 32'h41, 32'h00000077, 32'h0, 1'b0, 3, 1'b1);
    wait_idle();
    chk("m40_after", mem[8'h10], 32'hCAFE770D);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
